// File: rtl/rv32_wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rv32_wb_port_arbiter_pkg;

  typedef enum logic {WB_ARB_NORMAL, WB_ARB_STEAL} wb_arb_state_t;

  localparam int WB_ARB_MAX_LONG = 8;
  localparam int WB_ARB_CNT_W    = 8;

endpackage

// File: rtl/rv32_wb_port_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping, as one-hot
// grant plus index. Purely combinational.
module rv32_rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned and infers a latch.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/rv32_wb_port_arbiter.sv
// Shares the register-file write port between W-stage writeback and N_LONG
// long-latency units. Optional RV32_WB_ARB_PERF_EN adds steal/conflict counters.
module rv32_wb_port_arbiter
  import rv32_wb_port_arbiter_pkg::*;
#(
  parameter int N_LONG       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 pipe_we_i,
  input  logic [4:0]           pipe_rd_i,
  input  logic [31:0]          pipe_data_i,
  input  logic [N_LONG-1:0]    lu_valid_i,
  input  logic [5*N_LONG-1:0]  lu_rd_i,
  input  logic [32*N_LONG-1:0] lu_data_i,
  output logic [N_LONG-1:0]    lu_ready_o,
  output logic                 stall_w_o,
  output logic                 reg_write_enable_o,
  output logic [4:0]           reg_write_address_o,
  output logic [31:0]          reg_write_data_o
`ifdef RV32_WB_ARB_PERF_EN
  ,
  output logic [31:0]          steal_count_o,
  output logic [31:0]          conflict_count_o
`endif
);

  localparam int PTR_W = (N_LONG > 1) ? $clog2(N_LONG) : 1;
  localparam logic [WB_ARB_CNT_W-1:0] LIMIT = WB_ARB_CNT_W'(STARVE_LIMIT);

  wb_arb_state_t            state_q, state_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [WB_ARB_CNT_W-1:0]  cnt_q [N_LONG];
  logic [WB_ARB_CNT_W-1:0]  cnt_d [N_LONG];

  logic [4:0]               lu_rd   [N_LONG];
  logic [31:0]              lu_data [N_LONG];
  logic [N_LONG-1:0]        long_req, zero_req, starved;
  logic [N_LONG-1:0]        n_gnt, s_gnt, gnt;
  logic [PTR_W-1:0]         n_idx, s_idx, g_idx;
  logic                     n_any, s_any, g_any;
  logic                     pipe_req, any_limit;

  assign pipe_req = pipe_we_i && (pipe_rd_i != 5'd0);

  // Writes to x0 are dropped, so such long results are accepted without a slot.
  always_comb begin
    lu_rd    = '{default: '0};
    lu_data  = '{default: '0};
    long_req = '0;
    zero_req = '0;
    starved  = '0;
    for (int i = 0; i < N_LONG; i++) begin
      lu_rd[i]    = lu_rd_i[5*i +: 5];
      lu_data[i]  = lu_data_i[32*i +: 32];
      long_req[i] = lu_valid_i[i] && (lu_rd[i] != 5'd0);
      zero_req[i] = lu_valid_i[i] && (lu_rd[i] == 5'd0);
      starved[i]  = long_req[i] && (cnt_q[i] == LIMIT);
    end
  end

  rv32_rr_picker #(.N(N_LONG), .PTR_W(PTR_W)) u_normal_pick (
    .req (long_req),
    .ptr (rr_ptr_q),
    .gnt (n_gnt),
    .idx (n_idx),
    .any (n_any)
  );

  rv32_rr_picker #(.N(N_LONG), .PTR_W(PTR_W)) u_starve_pick (
    .req (starved),
    .ptr (rr_ptr_q),
    .gnt (s_gnt),
    .idx (s_idx),
    .any (s_any)
  );

  // State register, counters and round-robin pointer.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n_i) begin
      state_q  <= WB_ARB_NORMAL;
      rr_ptr_q <= '0;
      for (int i = 0; i < N_LONG; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < N_LONG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Long-unit grant: idle slots in NORMAL, one starved unit in STEAL.
  always_comb begin
    gnt   = '0;
    g_idx = '0;
    g_any = 1'b0;
    unique case (state_q)
      WB_ARB_NORMAL: begin
        if (!pipe_req && n_any) begin
          gnt   = n_gnt;
          g_idx = n_idx;
          g_any = 1'b1;
        end
      end
      WB_ARB_STEAL: begin
        if (s_any) begin
          gnt   = s_gnt;
          g_idx = s_idx;
          g_any = 1'b1;
        end
      end
    endcase
  end

  // Next-state, pointer and wait counters.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    any_limit = 1'b0;
    if (g_any) rr_ptr_d = (g_idx == PTR_W'(N_LONG - 1)) ? '0 : g_idx + 1'b1;
    for (int i = 0; i < N_LONG; i++) begin
      if (lu_ready_o[i])                          cnt_d[i] = '0;
      else if (long_req[i] && cnt_q[i] != LIMIT)  cnt_d[i] = cnt_q[i] + 1'b1;
      if (cnt_d[i] == LIMIT) any_limit = 1'b1;
    end
    unique case (state_q)
      WB_ARB_NORMAL: if (any_limit) state_d = WB_ARB_STEAL;
      WB_ARB_STEAL:  state_d = WB_ARB_NORMAL;
    endcase
  end

  // Outputs; the STEAL state itself is the registered stall.
  assign stall_w_o = (state_q == WB_ARB_STEAL);

  always_comb begin
    reg_write_enable_o  = 1'b0;
    reg_write_address_o = '0;
    reg_write_data_o    = '0;
    lu_ready_o          = '0;
    if (rst_n_i) begin
      lu_ready_o = gnt | zero_req;
      if (state_q == WB_ARB_NORMAL && pipe_req) begin
        reg_write_enable_o  = 1'b1;
        reg_write_address_o = pipe_rd_i;
        reg_write_data_o    = pipe_data_i;
      end else if (g_any) begin
        reg_write_enable_o  = 1'b1;
        reg_write_address_o = lu_rd[g_idx];
        reg_write_data_o    = lu_data[g_idx];
      end
    end
  end

`ifdef RV32_WB_ARB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      steal_count_o    <= '0;
      conflict_count_o <= '0;
    end else begin
      if (state_q == WB_ARB_STEAL) steal_count_o    <= steal_count_o + 32'd1;
      if (|long_req)               conflict_count_o <= conflict_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_wb_port_arbiter.sv
// Scoreboard bench for rv32_wb_port_arbiter (N_LONG=2, STARVE_LIMIT=4);
// expected write-port results are queued per driven cycle and popped at negedge.
module tb_rv32_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic [1:0]  lu_valid;
  logic [9:0]  lu_rd;
  logic [63:0] lu_data;
  logic [1:0]  lu_ready;
  logic        stall_w;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
`ifdef RV32_WB_ARB_PERF_EN
  logic [31:0] steal_count;
  logic [31:0] conflict_count;
`endif

  always #5 clk = ~clk;

  rv32_wb_port_arbiter #(.N_LONG(2), .STARVE_LIMIT(4)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .pipe_we_i           (pipe_we),
    .pipe_rd_i           (pipe_rd),
    .pipe_data_i         (pipe_data),
    .lu_valid_i          (lu_valid),
    .lu_rd_i             (lu_rd),
    .lu_data_i           (lu_data),
    .lu_ready_o          (lu_ready),
    .stall_w_o           (stall_w),
    .reg_write_enable_o  (we),
    .reg_write_address_o (waddr),
    .reg_write_data_o    (wdata)
`ifdef RV32_WB_ARB_PERF_EN
    ,
    .steal_count_o       (steal_count),
    .conflict_count_o    (conflict_count)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        pw;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic [1:0]  v;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
  } stim_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  ready;
    logic        stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, queue its expectation, compare at negedge, then advance.
  task automatic step(input string tag, input stim_t s, input exp_t e);
    exp_t x;
    rst_n     = s.rst_n;
    pipe_we   = s.pw;
    pipe_rd   = s.prd;
    pipe_data = s.pd;
    lu_valid  = s.v;
    lu_rd     = {s.r1, s.r0};
    lu_data   = {s.d1, s.d0};
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      check({tag, "_we"},    32'(we),       32'(x.we));
      check({tag, "_addr"},  32'(waddr),    32'(x.addr));
      check({tag, "_data"},  wdata,         x.data);
      check({tag, "_ready"}, 32'(lu_ready), 32'(x.ready));
      check({tag, "_stall"}, 32'(stall_w),  32'(x.stall));
    end
    @(posedge clk);
    #1;
  endtask

  localparam exp_t IDLE = '{1'b0, 5'd0, 32'h0, 2'b00, 1'b0};

  initial begin
    rst_n = 1'b0; pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hAA;
    lu_valid = 2'b11; lu_rd = {5'd8, 5'd7}; lu_data = {32'hCC, 32'hBB};
    @(posedge clk);
    #1;

    // Reset holds everything quiet even with every requester active.
    for (int i = 0; i < 2; i++)
      step("rst", '{1'b0, 1'b1, 5'd5, 32'hAA, 2'b11, 5'd7, 5'd8, 32'hBB, 32'hCC}, IDLE);
    step("rel0", '{1'b1, 1'b0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd8, 32'hBB, 32'hCC},
         '{1'b1, 5'd7, 32'hBB, 2'b01, 1'b0});
    step("rel1", '{1'b1, 1'b0, 5'd0, 32'h0, 2'b10, 5'd7, 5'd8, 32'hBB, 32'hCC},
         '{1'b1, 5'd8, 32'hCC, 2'b10, 1'b0});

    // Round-robin alternation from rr_ptr=0 with fresh data after each accept.
    step("rr0", '{1'b1, 1'b0, 5'd0, 32'h0, 2'b11, 5'd10, 5'd11, 32'h100, 32'h200},
         '{1'b1, 5'd10, 32'h100, 2'b01, 1'b0});
    step("rr1", '{1'b1, 1'b0, 5'd0, 32'h0, 2'b11, 5'd10, 5'd11, 32'h101, 32'h200},
         '{1'b1, 5'd11, 32'h200, 2'b10, 1'b0});
    step("rr2", '{1'b1, 1'b0, 5'd0, 32'h0, 2'b11, 5'd10, 5'd11, 32'h101, 32'h201},
         '{1'b1, 5'd10, 32'h101, 2'b01, 1'b0});
    step("rr3", '{1'b1, 1'b0, 5'd0, 32'h0, 2'b11, 5'd10, 5'd11, 32'h102, 32'h201},
         '{1'b1, 5'd11, 32'h201, 2'b10, 1'b0});
    step("rr4", '{1'b1, 1'b0, 5'd0, 32'h0, 2'b01, 5'd10, 5'd11, 32'h102, 32'h0},
         '{1'b1, 5'd10, 32'h102, 2'b01, 1'b0});

    // Pipe has priority; the long unit takes the next idle slot (wraps from ptr=1).
    step("pri0", '{1'b1, 1'b1, 5'd5, 32'hAA, 2'b01, 5'd7, 5'd0, 32'hBB, 32'h0},
         '{1'b1, 5'd5, 32'hAA, 2'b00, 1'b0});
    step("pri1", '{1'b1, 1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 32'hBB, 32'h0},
         '{1'b1, 5'd7, 32'hBB, 2'b01, 1'b0});

    // Long result to x0 is accepted alongside a pipe write; pipe to x0 is no request.
    step("x0lu", '{1'b1, 1'b1, 5'd3, 32'h11, 2'b01, 5'd0, 5'd0, 32'hDEAD, 32'h0},
         '{1'b1, 5'd3, 32'h11, 2'b01, 1'b0});
    step("x0pipe", '{1'b1, 1'b1, 5'd0, 32'h77, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0}, IDLE);

    // Fresh reset so the perf counters see the starvation scenario alone.
    step("rst2", '{1'b0, 1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0}, IDLE);

    // Starvation: four pipe writes, then a stolen slot, then the held pipe write.
    for (int i = 0; i < 4; i++)
      step("wait", '{1'b1, 1'b1, 5'd4, 32'h44, 2'b10, 5'd0, 5'd9, 32'h0, 32'h55},
           '{1'b1, 5'd4, 32'h44, 2'b00, 1'b0});
    step("steal", '{1'b1, 1'b1, 5'd4, 32'h44, 2'b10, 5'd0, 5'd9, 32'h0, 32'h55},
         '{1'b1, 5'd9, 32'h55, 2'b10, 1'b1});
    step("held", '{1'b1, 1'b1, 5'd4, 32'h44, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0},
         '{1'b1, 5'd4, 32'h44, 2'b00, 1'b0});
    step("idle", '{1'b1, 1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0}, IDLE);
`ifdef RV32_WB_ARB_PERF_EN
    check("steal_count", steal_count, 32'd1);
    check("conflict_count", conflict_count, 32'd5);
`endif

    // Reset during the STEAL cycle: no write, stall drops, unit re-granted after.
    for (int i = 0; i < 4; i++)
      step("wait2", '{1'b1, 1'b1, 5'd4, 32'h44, 2'b10, 5'd0, 5'd9, 32'h0, 32'h66},
           '{1'b1, 5'd4, 32'h44, 2'b00, 1'b0});
    step("rststeal", '{1'b0, 1'b1, 5'd4, 32'h44, 2'b10, 5'd0, 5'd9, 32'h0, 32'h66},
         '{1'b0, 5'd0, 32'h0, 2'b00, 1'b1});
    step("regrant", '{1'b1, 1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 32'h0, 32'h66},
         '{1'b1, 5'd9, 32'h66, 2'b10, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_wb_port_arbiter.md
Name: rv32_wb_port_arbiter

Overview:
Shares the register file's single write port between the in-order pipeline writeback and N_LONG long-latency units (divider, FPU, CSR/AMO results). The in-order pipeline normally has priority. Long units are arbitrated round-robin into idle writeback slots. A per-unit starvation counter makes the block steal one slot by stalling the W stage. Sits between the W stage and the write inputs of the decode-stage register file.

Parameters:
N_LONG, 2, number of long-latency requesters (1..8)
STARVE_LIMIT, 4, wait cycles before a slot is stolen (1..255)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset; synchronous, active-low
pipe_we_i  in  1  pipeline W-stage write request
pipe_rd_i  in  5  pipeline destination register
pipe_data_i  in  32  pipeline write data
lu_valid_i  in  N_LONG  long-unit result valid
lu_rd_i  in  5*N_LONG  long-unit destination, packed, unit i at [5i+:5]
lu_data_i  in  32*N_LONG  long-unit data, packed, unit i at [32i+:32]
lu_ready_o  out  N_LONG  long-unit result accepted this cycle
stall_w_o  out  1  registered; W stage and upstream must hold
reg_write_enable_o  out  1  register file write enable
reg_write_address_o  out  5  register file write address
reg_write_data_o  out  32  register file write data

Behaviour:
- Reset: the block samples rst_n_i=0 at the clock edge. It sets state=NORMAL, rr_ptr=0, all wait counters to 0, and stall_w_o=0. While rst_n_i=0, lu_ready_o and reg_write_enable_o are forced to 0; address and data outputs read 0. Reset mid-steal abandons the steal. No write occurs, and the unit keeps its valid asserted.
- Handshake: once raised, lu_valid_i[i] and its rd/data stay stable until lu_ready_o[i]=1. Transfer happens on valid&ready at the clock edge.
- Grant is combinational and completes in the same cycle. The register file captures at the same edge, so there is zero added latency.
- x0 handling: pipe_we_i with pipe_rd_i=0 counts as no request. A long request with rd=0 gets lu_ready_o=1 immediately and causes no write. Any number of these may complete in one cycle.
- State NORMAL:
  - If the pipe has a request, the port goes to the pipe.
  - Otherwise the port goes to the first valid long unit (rd!=0), searching from rr_ptr upward with wrap.
  - rr_ptr then becomes granted index+1 mod N_LONG.
- Wait counter i:
  - Increments each cycle lu_valid_i[i]&!lu_ready_o[i] with rd!=0.
  - Saturates at STARVE_LIMIT.
  - Clears on handshake.
- NORMAL -> STEAL when any counter equals STARVE_LIMIT at the edge. stall_w_o is registered at 1.
- State STEAL:
  - The pipe request is ignored; the pipeline holds it because stall_w_o=1.
  - The port goes to the first starved unit from rr_ptr.
  - rr_ptr advances as in NORMAL.
  - Next state is NORMAL, with stall_w_o=0.
  - Exactly one stolen slot per entry. Further starved units re-trigger on a later cycle.
- STEAL with no valid starved unit (cannot occur under the handshake rule): no write, return to NORMAL.
- Simultaneous pipe and long requests to the same rd in one cycle: the pipe writes first and the long unit waits. Ordering beyond that is the hazard unit's responsibility.

Optional Feature:
- Macro: RV32_WB_ARB_PERF_EN.
- Defined: adds ports steal_count_o[31:0] and conflict_count_o[31:0]. conflict_count_o counts cycles with at least one long unit waiting. steal_count_o counts STEAL cycles. Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package gets:
  - typedef enum logic {WB_ARB_NORMAL, WB_ARB_STEAL} wb_arb_state_t.
  - Constants WB_ARB_MAX_LONG=8 and WB_ARB_CNT_W=8.
- Sub-module rv32_rr_picker: N-bit request vector plus pointer in, one-hot grant plus index plus any-grant out, purely combinational. It is instantiated twice: once for normal grant, once for the starved-only mask.

Test Plan (N_LONG=2, STARVE_LIMIT=4):
1. rst_n_i=0 for 2 cycles with lu_valid_i=2'b11 and pipe_we_i=1 -> lu_ready_o=00, reg_write_enable_o=0, stall_w_o=0. Release reset -> normal grants resume.
2. pipe_we_i=1 rd=5 data=0xAA with lu0 valid rd=7 data=0xBB -> write x5=0xAA, lu_ready_o=00. Next cycle pipe_we_i=0 -> write x7=0xBB, lu_ready_o=01.
3. Pipe idle, lu0 and lu1 continuously valid (new data after each accept) -> grants alternate lu0, lu1, lu0, lu1 starting from rr_ptr=0.
4. pipe_we_i=1 every cycle, lu1 valid rd=9 data=0x55 -> 4 cycles of pipe writes, then stall_w_o=1 and write x9=0x55 with lu_ready_o=10. Next cycle stall_w_o=0 and the held pipe write completes.
5. lu0 valid rd=0 while pipe writes x3=0x11 -> lu_ready_o[0]=1 the same cycle, with only x3 written.
6. Reset asserted during the STEAL cycle of scenario 4 -> no write, stall_w_o=0 after the edge, lu1 re-granted after reset. With RV32_WB_ARB_PERF_EN, scenario 4 gives steal_count_o=1 and conflict_count_o=5.
